// File: rtl/add16_seq.sv
// add16_seq: nibble-serial add/subtract sequencer built around a single adder4 slice
module adder4 (
  output logic [3:0] S,
  output logic       Cout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);
  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
endmodule

module add16_seq #(
  parameter int WIDTH = 16,
  localparam int NIB = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry_r;
  logic [3:0]       s;
  logic             co;
  adder4 u_add (
    .S   (s),
    .Cout(co),
    .A   (a_r[4*idx +: 4]),
    .B   (b_r[4*idx +: 4]),
    .Cin (carry_r)
  );
  assign busy = state == RUN;
  assign done = state == DONE;
  // sum_r collects nibbles as they are produced; the visible result only moves on the final slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == RUN) begin
      sum_r[4*idx +: 4] <= s;
      carry_r           <= co;
      idx               <= idx + IW'(1);
      if (idx == IW'(NIB - 1)) begin
        sum   <= {s, sum_r[WIDTH-5:0]};
        cout  <= co;
        ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (s[3] != a_r[WIDTH-1]);
        state <= DONE;
      end
    end else if (start) begin
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= sub;
      idx     <= '0;
      sum_r   <= '0;
      state   <= RUN;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_add16_seq.sv
// tb_add16_seq: directed checks of the nibble-serial add/subtract sequencer
module tb_add16_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  int          passed = 0;
  int          total = 0;

  add16_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic op(input logic [15:0] x, input logic [15:0] y, input logic s,
                    input logic [15:0] es, input logic ec, input logic eo,
                    input bit timing, input string tag);
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (timing) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_nodone"}, done, 0);
      end
      tick;
    end
    chk({tag, "_done"}, done, 1);
    if (timing) chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    tick;
    if (timing) chk({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    tick;
    rst = 1'b0;
    tick;
    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1, "add");
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, "ripple");
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1, "addovf");
    op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1, "subneg");
    op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1, "subovf");
    // start re-pulsed and operands changed mid-run, then back-to-back start in DONE
    a = 16'h1234;
    b = 16'h4321;
    sub = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("ign_busy1", busy, 1);
    chk("ign_hold1", sum, 16'h7FFF);
    tick;
    a = 16'h1111;
    b = 16'h0F0F;
    sub = 1'b1;
    start = 1'b1;
    chk("ign_busy2", busy, 1);
    chk("ign_hold2", sum, 16'h7FFF);
    tick;
    start = 1'b0;
    a = 16'hFFFF;
    chk("ign_busy3", busy, 1);
    chk("ign_hold3", cout, 1);
    tick;
    chk("ign_busy4", busy, 1);
    chk("ign_hold4", sum, 16'h7FFF);
    tick;
    chk("ign_done", done, 1);
    chk("ign_sum", sum, 16'h5555);
    chk("ign_cout", cout, 0);
    chk("ign_ovf", ovf, 0);
    a = 16'h0100;
    b = 16'h0011;
    sub = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      chk("b2b_busy", busy, 1);
      chk("b2b_nodone", done, 0);
      tick;
    end
    chk("b2b_done", done, 1);
    chk("b2b_sum", sum, 16'h0111);
    tick;
    chk("b2b_done_once", done, 0);
    // asynchronous reset in cycle 3 aborts the operation
    a = 16'h1111;
    b = 16'h2222;
    sub = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    tick;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("abort_nodone", done, 0);
      chk("abort_idle", busy, 0);
      tick;
    end
    op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1, "after_rst");
    // low-nibble sweep against a behavioral model
    for (int hi = 0; hi < 2; hi++)
      for (int s = 0; s < 2; s++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++) begin
            logic [15:0] xa, yb, bb;
            logic [16:0] full;
            xa = (hi != 0) ? (16'hFFF0 | 16'(x)) : 16'(x);
            yb = (hi != 0) ? (16'hFFF0 | 16'(y)) : 16'(y);
            bb = (s != 0) ? ~yb : yb;
            full = {1'b0, xa} + {1'b0, bb} + 17'(s);
            op(xa, yb, s[0], full[15:0], full[16],
               (xa[15] == bb[15]) && (full[15] != xa[15]), 0, "sweep");
          end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
